// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
//
// Byte-addressable, little-endian data memory with a request/ready handshake
// and a fixed, parameterised access latency. Supports byte, halfword and word
// loads/stores, signed or unsigned load extension, and flags misaligned,
// out-of-range and illegal-size requests.
//
// Parameters:
//   ADDR_W      byte-address width, capacity is 2**ADDR_W bytes
//   LATENCY     wait cycles between accept and access (0..15)
//   INIT_BYTE0  value loaded into byte 0 at reset
//
// Ports:
//   clk              clock, rising edge
//   rstn             synchronous active-low reset
//   i_DMem_req       request strobe, accepted when o_DMem_ready is high
//   i_DMem_we        1 = store, 0 = load
//   i_DMem_size      00 byte, 01 half, 10 word, 11 illegal
//   i_DMem_unsigned  load zero-extends when 1, sign-extends when 0
//   i_DMem_addr      byte address
//   i_DMem_wData     store data, low bytes used for byte/half stores
//   o_DMem_ready     block can accept a request this cycle
//   o_DMem_valid     one-cycle response pulse
//   o_DMem_rData     load result, 0 for stores and errors
//   o_DMem_err       response flags misaligned / out-of-range / illegal size
//
// State table:
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | ready for a request; with LATENCY 0 the access is done on the
//           | accepting edge
//   ST_WAIT | counting down the latency; access on the edge where cnt is 0
//   ST_RESP | response cycle, o_DMem_valid high, not ready
// -----------------------------------------------------------------------------
module dmem_ctrl #(
    parameter int         ADDR_W     = 10,
    parameter int         LATENCY    = 1,
    parameter logic [7:0] INIT_BYTE0 = 8'h0a
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_DMem_req,
    input  logic        i_DMem_we,
    input  logic [1:0]  i_DMem_size,
    input  logic        i_DMem_unsigned,
    input  logic [31:0] i_DMem_addr,
    input  logic [31:0] i_DMem_wData,
    output logic        o_DMem_ready,
    output logic        o_DMem_valid,
    output logic [31:0] o_DMem_rData,
    output logic        o_DMem_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;

    logic [7:0]  mem [DEPTH];

    // Request captured at acceptance
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    // Operands of the access about to be performed. In IDLE the only access
    // that can happen is the LATENCY 0 one, which must use the live inputs
    // because the capture registers are being written on that same edge.
    logic        acc_we;
    logic [1:0]  acc_size;
    logic        acc_unsigned;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;

    logic             acc_err;
    logic [3:0]       lane_en;
    logic [ADDR_W-1:0] lane_addr [4];
    logic [7:0]       lane_rd   [4];
    logic [7:0]       lane_wd   [4];
    logic [3:0]       wr_en;
    logic [31:0]      acc_rdata;

    assign o_DMem_ready = rstn && (state == ST_IDLE);

    always_comb begin
        if (state == ST_IDLE) begin
            acc_we       = i_DMem_we;
            acc_size     = i_DMem_size;
            acc_unsigned = i_DMem_unsigned;
            acc_addr     = i_DMem_addr;
            acc_wdata    = i_DMem_wData;
        end else begin
            acc_we       = r_we;
            acc_size     = r_size;
            acc_unsigned = r_unsigned;
            acc_addr     = r_addr;
            acc_wdata    = r_wdata;
        end
    end

    always_comb begin
        acc_err = 1'b0;
        lane_en = 4'b0000;
        case (acc_size)
            2'b00: lane_en = 4'b0001;
            2'b01: begin
                lane_en = 4'b0011;
                acc_err = acc_addr[0];
            end
            2'b10: begin
                lane_en = 4'b1111;
                acc_err = (acc_addr[1:0] != 2'b00);
            end
            default: acc_err = 1'b1;
        endcase
        if (acc_addr[31:ADDR_W] != '0) begin
            acc_err = 1'b1;
        end
    end

    // Lane j always maps to address addr+j; an error-free access is aligned
    // and in range, so the low-bit addition never wraps for enabled lanes.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            lane_addr[j] = acc_addr[ADDR_W-1:0] + ADDR_W'(j);
            lane_rd[j]   = mem[lane_addr[j]];
            lane_wd[j]   = acc_wdata[8*j +: 8];
            wr_en[j]     = acc_we && !acc_err && lane_en[j];
        end
    end

    always_comb begin
        acc_rdata = 32'h0;
        case (acc_size)
            2'b00: acc_rdata = {{24{lane_rd[0][7] & ~acc_unsigned}}, lane_rd[0]};
            2'b01: acc_rdata = {{16{lane_rd[1][7] & ~acc_unsigned}}, lane_rd[1], lane_rd[0]};
            2'b10: acc_rdata = {lane_rd[3], lane_rd[2], lane_rd[1], lane_rd[0]};
            default: acc_rdata = 32'h0;
        endcase
        if (acc_err || acc_we) begin
            acc_rdata = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= ST_IDLE;
            cnt          <= 4'd0;
            o_DMem_valid <= 1'b0;
            o_DMem_rData <= 32'h0;
            o_DMem_err   <= 1'b0;
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= (i == 0) ? INIT_BYTE0 : 8'h00;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    o_DMem_valid <= 1'b0;
                    if (i_DMem_req) begin
                        r_we       <= i_DMem_we;
                        r_size     <= i_DMem_size;
                        r_unsigned <= i_DMem_unsigned;
                        r_addr     <= i_DMem_addr;
                        r_wdata    <= i_DMem_wData;
                        if (LATENCY == 0) begin
                            for (int j = 0; j < 4; j++) begin
                                if (wr_en[j]) begin
                                    mem[lane_addr[j]] <= lane_wd[j];
                                end
                            end
                            o_DMem_rData <= acc_rdata;
                            o_DMem_err   <= acc_err;
                            o_DMem_valid <= 1'b1;
                            state        <= ST_RESP;
                        end else begin
                            cnt   <= LAT_M1;
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        for (int j = 0; j < 4; j++) begin
                            if (wr_en[j]) begin
                                mem[lane_addr[j]] <= lane_wd[j];
                            end
                        end
                        o_DMem_rData <= acc_rdata;
                        o_DMem_err   <= acc_err;
                        o_DMem_valid <= 1'b1;
                        state        <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    o_DMem_valid <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: begin
                    o_DMem_valid <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
